// File: rtl/cic_decim_ctrl.sv
// Sequencer for a pipelined CIC decimator: gates the datapath sample enable, counts the
// decimation ratio, tracks the tagged result through the pipe and hands it out on valid/ready.
module cic_decim_ctrl #(
   parameter int DATA_W   = 25,
   parameter int RATIO_W  = 8,
   parameter int PIPE_LAT = 3,
   parameter int WARM_OUT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               cfg_valid,
   input  logic [RATIO_W-1:0] cfg_ratio,
   output logic               cfg_ready,
   input  logic               s_valid,
   output logic               cic_en,
   input  logic [DATA_W-1:0]  cic_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [DATA_W-1:0]  m_data,
   output logic               overrun,
   input  logic               ovr_clr,
   output logic [RATIO_W-1:0] phase
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WARM = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam int              WC_W      = (WARM_OUT > 1) ? $clog2(WARM_OUT + 1) : 1;
   localparam logic [WC_W-1:0] WARM_LAST = WC_W'((WARM_OUT > 0) ? WARM_OUT - 1 : 0);

   logic [1:0]          state;
   logic [RATIO_W-1:0]  ratio;
   logic [PIPE_LAT-2:0] tag;
   logic [PIPE_LAT-2:0] tag_nxt;
   logic                emit;
   logic                wrap;
   logic                capture;
   logic [WC_W-1:0]     warm_cnt;

   assign cfg_ready = (state == ST_IDLE);
   assign cic_en    = (state != ST_IDLE) && s_valid;
   assign wrap      = (phase == ratio - RATIO_W'(1));
   assign capture   = emit && (state == ST_RUN);

   // The emit register acts as the last tag stage, so only PIPE_LAT-1 tag bits are stored.
   always_comb begin
      // NOTE: default assignment first keeps this combinational block free of inferred latches.
      tag_nxt    = tag;
      tag_nxt[0] = wrap;
      for (int i = 1; i < PIPE_LAT - 1; i++) begin
         tag_nxt[i] = tag[i-1];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else if (!enable) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state <= (WARM_OUT == 0) ? ST_RUN : ST_WARM;
            ST_WARM: if (emit && (warm_cnt == WARM_LAST)) state <= ST_RUN;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ratio <= RATIO_W'(1);
      end else if (cfg_valid && cfg_ready) begin
         ratio <= (cfg_ratio == '0) ? RATIO_W'(1) : cfg_ratio;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase    <= '0;
         tag      <= '0;
         emit     <= 1'b0;
         warm_cnt <= '0;
      end else if (!enable) begin
         phase    <= '0;
         tag      <= '0;
         emit     <= 1'b0;
         warm_cnt <= '0;
      end else begin
         emit <= cic_en && tag[PIPE_LAT-2];
         if (cic_en) begin
            phase <= wrap ? '0 : phase + RATIO_W'(1);
            tag   <= tag_nxt;
         end
         if (emit && (state == ST_WARM)) warm_cnt <= warm_cnt + WC_W'(1);
      end
   end

   // A capture into a slot being drained this cycle reloads it without a bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (capture && (!m_valid || m_ready)) begin
         m_valid <= 1'b1;
         m_data  <= cic_data;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun <= 1'b0;
      end else if (capture && m_valid && !m_ready) begin
         overrun <= 1'b1;
      end else if (ovr_clr) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl: a cycle table for the R=4 warm-up/run/stop flow, plus
// hand sequences for overrun, async reset and a WARM_OUT=0, R=1 instance.
module tb_cic_decim_ctrl;

   localparam int DATA_W  = 25;
   localparam int RATIO_W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               enable, cfg_valid, s_valid, m_ready, ovr_clr;
   logic [RATIO_W-1:0] cfg_ratio;
   logic [DATA_W-1:0]  cic_data;
   logic               cfg_ready, cic_en, m_valid, overrun;
   logic [DATA_W-1:0]  m_data;
   logic [RATIO_W-1:0] phase;

   logic               enable_b, cfg_valid_b, s_valid_b, m_ready_b, ovr_clr_b;
   logic [RATIO_W-1:0] cfg_ratio_b;
   logic [DATA_W-1:0]  cic_data_b;
   logic               cfg_ready_b, cic_en_b, m_valid_b, overrun_b;
   logic [DATA_W-1:0]  m_data_b;
   logic [RATIO_W-1:0] phase_b;

   cic_decim_ctrl u_dut (
      .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid), .cfg_ratio(cfg_ratio),
      .cfg_ready(cfg_ready), .s_valid(s_valid), .cic_en(cic_en), .cic_data(cic_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .overrun(overrun),
      .ovr_clr(ovr_clr), .phase(phase)
   );

   cic_decim_ctrl #(.WARM_OUT(0)) u_dut_b (
      .clk(clk), .rst(rst), .enable(enable_b), .cfg_valid(cfg_valid_b), .cfg_ratio(cfg_ratio_b),
      .cfg_ready(cfg_ready_b), .s_valid(s_valid_b), .cic_en(cic_en_b), .cic_data(cic_data_b),
      .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .overrun(overrun_b),
      .ovr_clr(ovr_clr_b), .phase(phase_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic               en;
      logic               cv;
      logic [RATIO_W-1:0] cr;
      logic               sv;
      logic               mr;
      logic               x_en;
      logic               x_cr;
      logic [RATIO_W-1:0] x_ph;
      logic               x_mv;
      logic [DATA_W-1:0]  x_md;
   } vec_t;

   vec_t vt[$];

   function automatic void add(input int en, cv, cr, sv, mr, xe, xc, xp, xm, xd);
      vec_t v;
      v.en   = en[0];
      v.cv   = cv[0];
      v.cr   = cr[RATIO_W-1:0];
      v.sv   = sv[0];
      v.mr   = mr[0];
      v.x_en = xe[0];
      v.x_cr = xc[0];
      v.x_ph = xp[RATIO_W-1:0];
      v.x_mv = xm[0];
      v.x_md = xd[DATA_W-1:0];
      vt.push_back(v);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      // R=4, WARM_OUT=2, cic_data = row index. Tags at cycles 4,8,..; emits at 7,11,15,19,23.
      //    en cv cr sv mr | cic_en cfg_rdy phase m_valid m_data
      add(1, 1, 4, 1, 1,   0, 1, 0, 0,  0);  // 0: IDLE, load R=4 with enable
      add(1, 0, 0, 1, 1,   1, 0, 0, 0,  0);  // 1
      add(1, 0, 0, 1, 1,   1, 0, 1, 0,  0);
      add(1, 0, 0, 1, 1,   1, 0, 2, 0,  0);
      add(1, 0, 0, 1, 1,   1, 0, 3, 0,  0);
      add(1, 0, 0, 1, 1,   1, 0, 0, 0,  0);  // 5
      add(1, 0, 0, 1, 1,   1, 0, 1, 0,  0);
      add(1, 0, 0, 1, 1,   1, 0, 2, 0,  0);  // 7: first emit, discarded
      add(1, 0, 0, 1, 1,   1, 0, 3, 0,  0);
      add(1, 0, 0, 1, 1,   1, 0, 0, 0,  0);
      add(1, 0, 0, 1, 1,   1, 0, 1, 0,  0);  // 10
      add(1, 0, 0, 1, 1,   1, 0, 2, 0,  0);  // 11: second emit, discarded
      add(1, 0, 0, 1, 1,   1, 0, 3, 0,  0);
      add(1, 0, 0, 1, 1,   1, 0, 0, 0,  0);
      add(1, 0, 0, 1, 1,   1, 0, 1, 0,  0);
      add(1, 0, 0, 1, 1,   1, 0, 2, 0,  0);  // 15: first kept emit
      add(1, 0, 0, 1, 1,   1, 0, 3, 1, 15);
      add(1, 0, 0, 1, 1,   1, 0, 0, 0, 15);
      add(1, 0, 0, 1, 1,   1, 0, 1, 0, 15);
      add(1, 0, 0, 1, 1,   1, 0, 2, 0, 15);
      add(1, 0, 0, 1, 1,   1, 0, 3, 1, 19);  // 20
      add(1, 0, 0, 1, 1,   1, 0, 0, 0, 19);
      add(1, 0, 0, 1, 0,   1, 0, 1, 0, 19);
      add(1, 0, 0, 0, 0,   0, 0, 2, 0, 19);  // 23: emit, then a sample gap
      add(0, 0, 0, 1, 0,   1, 0, 2, 1, 23);  // 24: drop enable with phase=2, output pending
      add(0, 1, 0, 1, 0,   0, 1, 0, 1, 23);  // 25: IDLE, load ratio 0
      add(0, 0, 0, 1, 1,   0, 1, 0, 1, 23);
      add(0, 0, 0, 0, 0,   0, 1, 0, 0, 23);  // 27

      rst = 1'b0;
      enable = 0; cfg_valid = 0; cfg_ratio = '0; s_valid = 1; m_ready = 0; ovr_clr = 0;
      cic_data = '0;
      enable_b = 0; cfg_valid_b = 0; cfg_ratio_b = '0; s_valid_b = 0; m_ready_b = 0;
      ovr_clr_b = 0; cic_data_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_m_valid", 32'(m_valid), 0);
      check("reset_m_data", 32'(m_data), 0);
      check("reset_overrun", 32'(overrun), 0);
      check("reset_phase", 32'(phase), 0);
      check("reset_cic_en", 32'(cic_en), 0);
      check("reset_cfg_ready", 32'(cfg_ready), 1);
      rst = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         enable = vt[i].en; cfg_valid = vt[i].cv; cfg_ratio = vt[i].cr;
         s_valid = vt[i].sv; m_ready = vt[i].mr; ovr_clr = 0;
         cic_data = DATA_W'(i);
         #1;
         check($sformatf("t1_cic_en[%0d]", i), 32'(cic_en), 32'(vt[i].x_en));
         check($sformatf("t1_cfg_ready[%0d]", i), 32'(cfg_ready), 32'(vt[i].x_cr));
         check($sformatf("t1_phase[%0d]", i), 32'(phase), 32'(vt[i].x_ph));
         check($sformatf("t1_m_valid[%0d]", i), 32'(m_valid), 32'(vt[i].x_mv));
         check($sformatf("t1_m_data[%0d]", i), 32'(m_data), 32'(vt[i].x_md));
         check($sformatf("t1_overrun[%0d]", i), 32'(overrun), 0);
         @(posedge clk);
         #1;
      end
      check("ratio_zero_loads_one", 32'(u_dut.ratio), 1);

      // R=2 loaded together with enable; tags at even cycles, emits at odd; keep from 9.
      for (int k = 0; k <= 16; k++) begin
         enable = 1; cfg_valid = (k == 0); cfg_ratio = 8'd2; s_valid = 1;
         m_ready = (k == 15); ovr_clr = (k == 13 || k == 14);
         cic_data = DATA_W'(32'h100 + k);
         #1;
         if (k == 0) check("t3_cfg_ready", 32'(cfg_ready), 1);
         if (k == 1) check("t3_phase1", 32'(phase), 0);
         if (k == 2) check("t3_phase2", 32'(phase), 1);
         if (k == 3) check("t3_phase3", 32'(phase), 0);
         if (k == 9) begin
            check("t3_warm_no_valid", 32'(m_valid), 0);
            check("t3_warm_no_load", 32'(m_data), 23);
         end
         if (k == 10) begin
            check("t3_first_valid", 32'(m_valid), 1);
            check("t3_first_data", 32'(m_data), 32'h109);
         end
         if (k == 11) check("t3_no_ovr_yet", 32'(overrun), 0);
         if (k == 12) begin
            check("t3_ovr_set", 32'(overrun), 1);
            check("t3_data_held", 32'(m_data), 32'h109);
            check("t3_valid_held", 32'(m_valid), 1);
         end
         if (k == 14) check("t3_set_beats_clr", 32'(overrun), 1);
         if (k == 15) begin
            check("t3_ovr_cleared", 32'(overrun), 0);
            check("t3_data_still_held", 32'(m_data), 32'h109);
         end
         if (k == 16) begin
            check("t4_valid_stays", 32'(m_valid), 1);
            check("t4_data_reload", 32'(m_data), 32'h10F);
            check("t4_no_overrun", 32'(overrun), 0);
         end
         if (k < 16) begin
            @(posedge clk);
            #1;
         end
      end

      // Async reset between clock edges while RUN with a pending output.
      #2;
      rst = 1'b0;
      #1;
      check("t6_m_valid", 32'(m_valid), 0);
      check("t6_m_data", 32'(m_data), 0);
      check("t6_overrun", 32'(overrun), 0);
      check("t6_phase", 32'(phase), 0);
      check("t6_cic_en", 32'(cic_en), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         enable = 1; cfg_valid = (k == 0); cfg_ratio = 8'd2; s_valid = 1;
         m_ready = 1; ovr_clr = 0;
         cic_data = DATA_W'(32'h200 + k);
         #1;
         if (k < 10) check($sformatf("t6_warm_discard[%0d]", k), 32'(m_valid), 0);
         if (k == 10) begin
            check("t6_first_valid", 32'(m_valid), 1);
            check("t6_first_data", 32'(m_data), 32'h209);
         end
         @(posedge clk);
         #1;
      end

      // WARM_OUT=0, R=1, samples every other cycle: first tag at 1, first m_valid at 7.
      for (int k = 0; k <= 12; k++) begin
         enable_b = 1; s_valid_b = (k % 2 == 1); m_ready_b = 1;
         cic_data_b = DATA_W'(32'h300 + k);
         #1;
         check($sformatf("t2_cic_en[%0d]", k), 32'(cic_en_b), (k % 2 == 1) ? 1 : 0);
         check($sformatf("t2_m_valid[%0d]", k), 32'(m_valid_b),
               (k >= 7 && k % 2 == 1) ? 1 : 0);
         if (k >= 7 && k % 2 == 1)
            check($sformatf("t2_m_data[%0d]", k), 32'(m_data_b), 32'h300 + k - 1);
         check($sformatf("t2_phase[%0d]", k), 32'(phase_b), 0);
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cic_decim_ctrl.md
Name: cic_decim_ctrl

Overview:
- Sequencer for the pipelined CIC decimator datapath (3 enable-gated pipeline stages, 25-bit data).
- Gates the datapath sample enable and counts the runtime-configurable decimation ratio R.
- Tracks which pipeline result is the decimated sample, discards warm-up outputs, and presents decimated samples on a valid/ready output with overrun detection.
- Replaces the datapath's second-clock output path with single-clock decimation.

Parameters:
- DATA_W, 25, datapath sample width.
- RATIO_W, 8, width of ratio register and phase counter.
- PIPE_LAT, 3, number of enable-gated pipeline stages in the datapath (≥2).
- WARM_OUT, 2, decimated outputs discarded after each start (0 allowed).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  run request; 0 forces IDLE.
- cfg_valid  in  1  ratio load request.
- cfg_ratio  in  RATIO_W  new decimation ratio R.
- cfg_ready  out  1  ratio load accepted when cfg_valid&cfg_ready.
- s_valid  in  1  input-rate sample strobe.
- cic_en  out  1  datapath data_i_en.
- cic_data  in  DATA_W  datapath final-stage result.
- m_valid  out  1  decimated sample available.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  decimated sample.
- overrun  out  1  sticky: a decimated sample was dropped.
- ovr_clr  in  1  clears overrun.
- phase  out  RATIO_W  current phase count.

Behaviour:
- Reset (rst=0, async): state=IDLE; ratio register=1; phase=0; tag pipe=0; emit=0; warm count=0; m_valid=0; m_data=0; overrun=0; cic_en=0.
- States:
  - IDLE: cic_en=0; cfg_ready=1.
  - WARM and RUN: cic_en=s_valid (combinational); cfg_ready=0.
- Transitions:
  - IDLE→WARM when enable=1. If WARM_OUT=0, go directly to RUN.
  - WARM→RUN on the WARM_OUT-th emit.
  - Any state→IDLE when enable=0; this has priority.
  - Entering IDLE clears phase, tag pipe, emit and warm count. It does not clear m_valid/m_data; a pending sample stays until m_ready.
- Config:
  - Ratio loads on cfg_valid&cfg_ready.
  - cfg_ratio=0 loads as 1.
  - Simultaneous cfg load and enable=1 in IDLE: the new ratio is used from the first sample.
- Phase counter:
  - Increments on cic_en.
  - On cic_en with phase==R-1: wraps to 0 and injects tag=1 into tag pipe stage 0. Otherwise injects 0.
  - R=1: every sample tagged.
- Tag pipe:
  - PIPE_LAT bits, shifts only on cic_en, in lockstep with the datapath.
  - emit register <= cic_en & tag[PIPE_LAT-2]. Otherwise emit=0.
- Capture on emit=1 (cic_data now holds the tagged result):
  - WARM: discard, increment warm count.
  - RUN, output slot free: m_data<=cic_data, m_valid<=1.
  - RUN, m_valid&m_ready same cycle: handshake completes and the new sample loads; no overrun.
  - RUN, m_valid&!m_ready: new sample dropped, m_data held, overrun<=1.
- Latency: with continuous s_valid, the tagged sample at cycle t gives m_valid high at cycle t+PIPE_LAT+1 (t+4 at defaults). Gaps in s_valid stretch latency by the gap length.
- Output handshake: m_valid falls after m_valid&m_ready unless reloaded that cycle. m_data is stable while m_valid&!m_ready.
- overrun: set has priority over ovr_clr in the same cycle.
- Reset mid-operation: everything returns to reset values immediately; any pending output is lost.

Test Plan:
1. Reset, load R=4, enable=1, WARM_OUT=2, continuous s_valid, cic_data=cycle index, m_ready=1 → first two emits discarded. m_valid pulses 1 cycle in 4 thereafter, m_data = cic_data at the cycle after each tag reaches the last stage. Phase sequence 0,1,2,3,0.
2. R=1, WARM_OUT=0, s_valid high every other cycle → m_valid once per two cycles. Latency from the first tagged sample = 2·PIPE_LAT cycles; cic_en mirrors s_valid.
3. R=2, run, hold m_ready=0 across two emits → first sample held, overrun=1 at the second. Assert ovr_clr together with a third emit → overrun stays 1. Clear later → overrun=0.
4. Capture coincides with m_valid&m_ready → no overrun, m_data updates to the new value, m_valid stays 1.
5. Deassert enable mid-frame with phase=2 and a pending output → cic_en=0 next cycle, phase=0. m_valid held until m_ready; cfg_valid with cfg_ratio=0 accepted and R reads back as 1.
6. Drive rst=0 asynchronously mid-RUN between clock edges → all outputs 0 immediately. After release with enable=1, WARM discards WARM_OUT outputs again.
